// File: rtl/BasicTypes.sv
// -----------------------------------------------------------------------------
// BasicTypes: shared types and constants for the UART transmit path.
//   UART_CLKS_PER_BIT : default number of clock cycles per serial bit.
//   UartTxState       : serializer state encoding (IDLE, START, DATA, STOP).
// -----------------------------------------------------------------------------
package BasicTypes;

    localparam int UART_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } UartTxState;

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo: byte FIFO that buffers bytes waiting for the serializer.
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset, empties the FIFO
//   push  in   write din at this edge (ignored while full)
//   pop   in   drop the head entry at this edge (ignored while empty)
//   din   in   byte to write
//   dout  out  current head entry (valid while empty=0)
//   count out  number of stored entries, 0..DEPTH
//   full  out  count == DEPTH
//   empty out  count == 0
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == {CW{1'b0}});
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];

    // A push while full is dropped even when a pop happens in the same cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx: buffered 8N1 UART transmitter.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset; aborts any frame, flushes FIFO
//   uart     in   byte to send, sampled when uart_we=1
//   uart_we  in   one-cycle write strobe
//   tx       out  serial line (registered, idle high)
//   busy     out  FIFO non-empty or a frame in flight
//   full     out  FIFO holds FIFO_DEPTH bytes
//   overflow out  sticky: a write was dropped because the FIFO was full
// A frame is start(0), 8 data bits LSB first, stop(1), each CLKS_PER_BIT cycles.
// Back-to-back frames leave STOP straight into START with no idle cycle.
// -----------------------------------------------------------------------------
module uart_tx
    import BasicTypes::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart,
    input  logic       uart_we,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    UartTxState    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;

    logic          fifo_pop;
    logic [7:0]    fifo_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_we),
        .pop   (fifo_pop),
        .din   (uart),
        .dout  (fifo_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx       = tx_q;
    assign full     = fifo_full;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) | (fifo_count != {CW{1'b0}});

    // Serializer next-state: baud timing, bit sequencing, FIFO pop and line level.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + BW'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q | (uart_we & fifo_full);

        case (state_q)
            IDLE: begin
                baud_d = {BW{1'b0}};
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_data;
                    bit_d    = 3'd0;
                    state_d  = START;
                    tx_d     = 1'b0;
                end else begin
                    state_d  = IDLE;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = {BW{1'b0}};
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    tx_d    = 1'b0;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = {BW{1'b0}};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Shift right so the next data bit is always at shift_q[0].
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    tx_d = shift_q[0];
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = {BW{1'b0}};
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_data;
                        bit_d    = 3'd0;
                        state_d  = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d  = IDLE;
                        tx_d     = 1'b1;
                    end
                end else begin
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = {BW{1'b0}};
                bit_d   = 3'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Serializer state, counters, shift register, line and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= {BW{1'b0}};
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] uart = 8'h00;
    logic       uart_we = 1'b0;
    logic       tx;
    logic       busy;
    logic       full;
    logic       overflow;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    bit         rx_active = 1'b0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart     (uart),
        .uart_we  (uart_we),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at time %0t", name, got, want, $time);
    endtask

    // Bench UART receiver: samples the line mid-bit and scores bytes against exp_q.
    initial begin
        int         cnt;
        logic [7:0] rx_byte;
        logic [7:0] e;
        cnt = 0;
        rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt >= 6 && cnt <= 34 && ((cnt - 6) % CPB) == 0)
                    rx_byte[(cnt - 6) / CPB] = tx;
                if (cnt == 38) begin
                    chk("rx_stop_bit", {31'd0, tx}, 32'd1);
                    chk("rx_frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rx_byte", {24'd0, rx_byte}, {24'd0, e});
                    end
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        uart_we = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_full", {31'd0, full}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
    endtask

    // One-cycle write strobe; the byte is queued as expected output when acc=1.
    task automatic wr(input logic [7:0] d, input bit acc);
        uart = d;
        uart_we = 1'b1;
        if (acc) exp_q.push_back(d);
        @(posedge clk);
        #1 uart_we = 1'b0;
    endtask

    // Cycle-exact check of the line: bits[k] is the k-th bit period, CPB cycles each.
    task automatic run_line(input logic [19:0] bits, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                chk("line_bit", {31'd0, tx}, {31'd0, bits[b]});
                chk("line_busy", {31'd0, busy}, 32'd1);
            end
        end
    endtask

    task automatic check_idle();
        @(negedge clk);
        chk("end_tx_high", {31'd0, tx}, 32'd1);
        chk("end_busy_low", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((busy || rx_active || exp_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", {31'd0, n < limit}, 32'd1);
        chk("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // line[0] = start bit ... line[9] = stop bit
    } vec_t;

    initial begin
        vec_t vecs[6];
        bit   stayed;
        logic [7:0] r;

        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        bit   stayed;
        logic [7:0] r;

        vecs[0] = '{data: 8'h55, line: 10'h2AA};
        vecs[1] = '{data: 8'hA3, line: 10'h346};
        vecs[2] = '{data: 8'h00, line: 10'h200};
        vecs[3] = '{data: 8'hFF, line: 10'h3FE};
        vecs[4] = '{data: 8'h01, line: 10'h202};
        vecs[5] = '{data: 8'h80, line: 10'h300};

        do_reset();

        // Single frames from idle: latency of one edge, 10 bit periods, then idle.
        for (int i = 0; i < 6; i++) begin
            wr(vecs[i].data, 1'b1);
            @(negedge clk);
            chk("pre_start_tx_high", {31'd0, tx}, 32'd1);
            chk("pre_start_busy", {31'd0, busy}, 32'd1);
            run_line({10'h000, vecs[i].line}, 10);
            check_idle();
            wait_drain(100);
        end

        // Two writes on consecutive cycles: 80 cycles of back-to-back frames.
        wr(8'h00, 1'b1);
        wr(8'hFF, 1'b1);
        run_line({10'h3FE, 10'h200}, 20);
        check_idle();
        wait_drain(100);

        // 18 consecutive writes: 17th fills the FIFO, 18th dropped.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            wr(8'(i), i < 17);
            if (i == 15) chk("fill_not_full_15", {31'd0, full}, 32'd0);
            if (i == 16) begin
                chk("fill_full_17", {31'd0, full}, 32'd1);
                chk("fill_no_overflow_17", {31'd0, overflow}, 32'd0);
            end
            if (i == 17) chk("fill_overflow_18", {31'd0, overflow}, 32'd1);
        end
        wait_drain(1500);
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);

        // Write while full on the same edge STOP pops the next byte.
        do_reset();
        for (int i = 0; i < 17; i++) wr(8'h20 + 8'(i), 1'b1);
        repeat (24) begin
            @(posedge clk);
            #1;
        end
        chk("full_before_drop", {31'd0, full}, 32'd1);
        @(negedge clk);
        chk("stop_bit_before_pop", {31'd0, tx}, 32'd1);
        wr(8'hEE, 1'b0);
        chk("drop_overflow", {31'd0, overflow}, 32'd1);
        chk("drop_not_full_after_pop", {31'd0, full}, 32'd0);
        @(negedge clk);
        chk("zero_gap_start", {31'd0, tx}, 32'd0);
        wait_drain(1500);

        // Reset during data bit 3 with 5 bytes queued behind the active frame.
        do_reset();
        for (int i = 0; i < 6; i++) wr(8'h30 + 8'(i), 1'b0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        chk("bit3_low_before_rst", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_tx_high", {31'd0, tx}, 32'd1);
        chk("abort_busy_low", {31'd0, busy}, 32'd0);
        chk("abort_full_low", {31'd0, full}, 32'd0);
        chk("abort_overflow_low", {31'd0, overflow}, 32'd0);
        stayed = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) stayed = 1'b0;
        end
        chk("abort_no_more_frames", {31'd0, stayed}, 32'd1);

        // 40 random bytes in pairs every two frame times; pointers wrap.
        do_reset();
        for (int p = 0; p < 20; p++) begin
            r = 8'($urandom_range(255));
            wr(r, 1'b1);
            r = 8'($urandom_range(255));
            wr(r, 1'b1);
            repeat (78) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain(500);
        chk("paced_no_overflow", {31'd0, overflow}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
